// File: rtl/quiet_time_monitor.sv
// ============================================================================
// Module   : quiet_time_monitor
// Purpose  : Observes an enable vector; flags non-one-hot samples and
//            quiet gaps outside MIN_QUIET..MAX_QUIET cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quiet_time_monitor #(
  parameter int EN_WIDTH  = 2,
  parameter int MIN_QUIET = 0,
  parameter int MAX_QUIET = 0,
  parameter int UNBOUNDED = 0,
  parameter int CNT_WIDTH = 8,
  parameter int QW        = $clog2(MAX_QUIET + 2)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 chk_en,
  input  logic                 clear,
  input  logic [EN_WIDTH-1:0]  en,
  output logic                 err_onehot,
  output logic                 err_short,
  output logic                 err_long,
  output logic [2:0]           err_sticky,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [QW-1:0]        quiet_len
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_QUIET  = 2'd2;
  localparam int         CW1      = CNT_WIDTH + 1;

  logic                 en_zero;
  logic                 en_onehot;
  logic                 onehot_d, short_d, long_d;
  logic                 onehot_q, short_q, long_q;
  logic [QW-1:0]        cnt_q;
  logic [2:0]           sticky_d, sticky_q;
  logic [CNT_WIDTH-1:0] count_d, count_q, count_base;
  logic [CW1-1:0]       count_sum;
  logic [1:0]           npulse;

  assign en_zero   = (en == '0);
  assign en_onehot = ($countones(en) == 1);

  if (MAX_QUIET == 0) begin : g_strict
    assign cnt_q = '0;

    always_comb begin
      onehot_d = chk_en && !en_onehot;
      short_d  = 1'b0;
      long_d   = 1'b0;
    end
  end else begin : g_gap
    logic [1:0]    state_d, state_q;
    logic [QW-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!chk_en) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE:   if (!en_zero) state_d = S_ACTIVE;
          S_ACTIVE: if (en_zero) begin
                      state_d = S_QUIET;
                      cnt_d   = QW'(1);
                    end
          S_QUIET:  if (!en_zero) begin
                      state_d = S_ACTIVE;
                      cnt_d   = '0;
                    end else if (UNBOUNDED == 0 && int'(cnt_q) == MAX_QUIET) begin
                      state_d = S_IDLE;
                      cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                      cnt_d = cnt_q + 1'b1;
                    end
          default: begin
                      state_d = S_IDLE;
                      cnt_d   = '0;
                    end
        endcase
      end
    end

    always_comb begin
      onehot_d = 1'b0;
      short_d  = 1'b0;
      long_d   = 1'b0;
      if (chk_en) begin
        case (state_q)
          S_IDLE, S_ACTIVE: onehot_d = !en_zero && !en_onehot;
          S_QUIET: begin
            if (!en_zero) begin
              onehot_d = !en_onehot;
              short_d  = int'(cnt_q) < MIN_QUIET;
            end else begin
              long_d = (UNBOUNDED == 0) && (int'(cnt_q) == MAX_QUIET);
            end
          end
          default: onehot_d = 1'b0;
        endcase
      end
    end
  end

  if (MAX_QUIET != 0 && MIN_QUIET > MAX_QUIET) begin : g_chk_range
    $error("quiet_time_monitor: MIN_QUIET exceeds MAX_QUIET");
  end
  if (MAX_QUIET != 0 && UNBOUNDED != 0 && MIN_QUIET == 0) begin : g_chk_vacuous
    $warning("quiet_time_monitor: gap check is vacuous with MIN_QUIET=0 and UNBOUNDED=1");
  end

  // Clear acts first so a pulse landing in the same cycle survives it.
  always_comb begin
    npulse     = {1'b0, onehot_d} + {1'b0, short_d} + {1'b0, long_d};
    count_base = clear ? '0 : count_q;
    count_sum  = {1'b0, count_base} + CW1'(npulse);
    count_d    = count_sum[CNT_WIDTH] ? '1 : count_sum[CNT_WIDTH-1:0];
    sticky_d   = (clear ? 3'b000 : sticky_q) | {long_d, short_d, onehot_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot_q <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      sticky_q <= 3'b000;
      count_q  <= '0;
    end else begin
      onehot_q <= onehot_d;
      short_q  <= short_d;
      long_q   <= long_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign err_onehot = onehot_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
  assign err_sticky = sticky_q;
  assign err_count  = count_q;
  assign quiet_len  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_quiet_time_monitor.sv
// ============================================================================
// Module   : tb_quiet_time_monitor
// Purpose  : Vector table with scoreboard for gap mode plus strict-mode and
//            reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quiet_time_monitor;

  typedef struct {
    logic [3:0] en;
    logic       chk;
    logic       clr;
    logic [2:0] pls;  // {long, short, onehot}
    logic [2:0] stk;
    logic [2:0] cnt;
    logic [2:0] ql;
  } vec_t;

  typedef struct {
    logic       onehot;
    logic [7:0] cnt;
  } svec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       chk_en = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] en = 4'b0000;
  logic       err_onehot, err_short, err_long;
  logic [2:0] err_sticky;
  logic [2:0] err_count;
  logic [2:0] quiet_len;

  logic       s_chk = 1'b1;
  logic       s_clr = 1'b0;
  logic [1:0] s_en = 2'b01;
  logic       s_onehot, s_short, s_long;
  logic [2:0] s_sticky;
  logic [7:0] s_count;
  logic [0:0] s_qlen;

  int n_vec = 0;
  int n_miss = 0;

  vec_t  tbl[$];
  vec_t  sb[$];
  svec_t ssb[$];

  always #5 clk = ~clk;

  quiet_time_monitor #(
    .EN_WIDTH(4), .MIN_QUIET(2), .MAX_QUIET(4), .UNBOUNDED(0), .CNT_WIDTH(3)
  ) u_gap (
    .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .clear(clear), .en(en),
    .err_onehot(err_onehot), .err_short(err_short), .err_long(err_long),
    .err_sticky(err_sticky), .err_count(err_count), .quiet_len(quiet_len)
  );

  quiet_time_monitor #(
    .EN_WIDTH(2), .MIN_QUIET(0), .MAX_QUIET(0), .UNBOUNDED(0), .CNT_WIDTH(8)
  ) u_strict (
    .clk(clk), .reset_n(reset_n), .chk_en(s_chk), .clear(s_clr), .en(s_en),
    .err_onehot(s_onehot), .err_short(s_short), .err_long(s_long),
    .err_sticky(s_sticky), .err_count(s_count), .quiet_len(s_qlen)
  );

  function automatic void add(input logic [3:0] e, input logic c, input logic r,
                              input logic [2:0] p, input logic [2:0] s,
                              input logic [2:0] n, input logic [2:0] q);
    vec_t v;
    v.en = e; v.chk = c; v.clr = r; v.pls = p; v.stk = s; v.cnt = n; v.ql = q;
    tbl.push_back(v);
  endfunction

  task automatic check_gap(input string tag);
    vec_t x;
    x = sb.pop_front();
    n_vec++;
    if ({err_long, err_short, err_onehot} !== x.pls) begin
      n_miss++;
      $display("FAIL %s pulses: got %b want %b", tag, {err_long, err_short, err_onehot}, x.pls);
    end
    if (err_sticky !== x.stk) begin
      n_miss++;
      $display("FAIL %s sticky: got %b want %b", tag, err_sticky, x.stk);
    end
    if (err_count !== x.cnt) begin
      n_miss++;
      $display("FAIL %s count: got %0d want %0d", tag, err_count, x.cnt);
    end
    if (quiet_len !== x.ql) begin
      n_miss++;
      $display("FAIL %s quiet_len: got %0d want %0d", tag, quiet_len, x.ql);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    en = v.en; chk_en = v.chk; clear = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_gap($sformatf("vec%0d", idx));
  endtask

  task automatic s_apply(input logic [1:0] e, input logic p, input logic [7:0] n);
    svec_t x;
    @(negedge clk);
    s_en = e;
    x.onehot = p; x.cnt = n;
    ssb.push_back(x);
    @(posedge clk);
    #1;
    x = ssb.pop_front();
    n_vec++;
    if (s_onehot !== x.onehot || s_short !== 1'b0 || s_long !== 1'b0) begin
      n_miss++;
      $display("FAIL strict en=%b pulses: got %b%b%b want 00%b", e, s_long, s_short, s_onehot, x.onehot);
    end
    if (s_count !== x.cnt) begin
      n_miss++;
      $display("FAIL strict en=%b count: got %0d want %0d", e, s_count, x.cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vec_t z;

    // Legal gap of 3
    add(4'b0001, 1, 0, 3'b000, 3'b000, 0, 0);
    add(4'b0000, 1, 0, 3'b000, 3'b000, 0, 1);
    add(4'b0000, 1, 0, 3'b000, 3'b000, 0, 2);
    add(4'b0000, 1, 0, 3'b000, 3'b000, 0, 3);
    add(4'b0100, 1, 0, 3'b000, 3'b000, 0, 0);
    // Short gap
    add(4'b0000, 1, 0, 3'b000, 3'b000, 0, 1);
    add(4'b0010, 1, 0, 3'b010, 3'b010, 1, 0);
    // Long gap, then silence in IDLE, then activity without err_short
    add(4'b0001, 1, 0, 3'b000, 3'b010, 1, 0);
    for (int i = 1; i <= 4; i++) add(4'b0000, 1, 0, 3'b000, 3'b010, 1, 3'(i));
    add(4'b0000, 1, 0, 3'b100, 3'b110, 2, 0);
    for (int i = 0; i < 10; i++) add(4'b0000, 1, 0, 3'b000, 3'b110, 2, 0);
    add(4'b0001, 1, 0, 3'b000, 3'b110, 2, 0);
    // Combined short+onehot, saturating at 7
    add(4'b0001, 1, 1, 3'b000, 3'b000, 0, 0);
    c = 0;
    for (int r = 0; r < 5; r++) begin
      add(4'b0000, 1, 0, 3'b000, (r == 0) ? 3'b000 : 3'b011, 3'(c), 1);
      c = (c + 2 > 7) ? 7 : c + 2;
      add(4'b0011, 1, 0, 3'b011, 3'b011, 3'(c), 0);
      add(4'b0001, 1, 0, 3'b000, 3'b011, 3'(c), 0);
    end
    // Clear coinciding with a single short pulse
    add(4'b0000, 1, 0, 3'b000, 3'b011, 7, 1);
    add(4'b0010, 1, 1, 3'b010, 3'b010, 1, 0);
    // chk_en gating: no pulse on bad en, flags retained, gap abandoned
    add(4'b1111, 0, 0, 3'b000, 3'b010, 1, 0);
    add(4'b0001, 1, 0, 3'b000, 3'b010, 1, 0);
    add(4'b0000, 1, 0, 3'b000, 3'b010, 1, 1);
    add(4'b0000, 0, 0, 3'b000, 3'b010, 1, 0);
    add(4'b0010, 1, 0, 3'b000, 3'b010, 1, 0);
    // Lead-in to mid-gap reset
    add(4'b0000, 1, 0, 3'b000, 3'b010, 1, 1);
    add(4'b0000, 1, 0, 3'b000, 3'b010, 1, 2);
    add(4'b0000, 1, 0, 3'b000, 3'b010, 1, 3);

    // Reset state while reset_n is held low
    repeat (2) @(posedge clk);
    #1;
    z.en = 4'b0000; z.chk = 1; z.clr = 0; z.pls = 3'b000; z.stk = 3'b000; z.cnt = 0; z.ql = 0;
    sb.push_back(z);
    check_gap("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Asynchronous reset in the middle of a 3-cycle gap
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back(z);
    check_gap("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) apply(z, 100 + i);

    // Strict mode: zero and multi-hot both flagged
    s_apply(2'b01, 1'b0, 8'd0);
    s_apply(2'b00, 1'b1, 8'd1);
    s_apply(2'b11, 1'b1, 8'd2);
    s_apply(2'b10, 1'b0, 8'd2);
    n_vec++;
    if (s_sticky !== 3'b001) begin
      n_miss++;
      $display("FAIL strict sticky: got %b want 001", s_sticky);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
